// File: rtl/ft245_sync_device.sv
// Device-side FT245 synchronous FIFO model: host byte stream <-> RX/TX FIFOs <-> FPGA strobes.
// RX and TX FIFOs are show-ahead. TX bytes become visible to the host only once they are committed.
module ft245_sync_device #(
  parameter int RX_AW    = 4,
  parameter int TX_AW    = 4,
  parameter int PKT_SIZE = 8
) (
  input  logic       ft_clkout,
  input  logic       rst_n,
  input  logic       ft_oen,
  input  logic       ft_rdn,
  input  logic       ft_wrn,
  input  logic       ft_siwun,
  input  logic       ft_pwrsavn,
  input  logic [7:0] ft_data_in,
  output logic       ft_rxfn,
  output logic       ft_txen,
  output logic [7:0] ft_data_out,
  output logic       ft_data_oe,
  input  logic [7:0] host_tx_data,
  input  logic       host_tx_valid,
  output logic       host_tx_ready,
  output logic [7:0] host_rx_data,
  output logic       host_rx_valid,
  input  logic       host_rx_ready,
  output logic       proto_err
);
  localparam int RX_DEPTH = 1 << RX_AW;
  localparam int TX_DEPTH = 1 << TX_AW;
  localparam logic [TX_AW:0] PKT_THR = (TX_AW + 1)'(PKT_SIZE);

  logic [7:0] rx_mem_q [RX_DEPTH];
  logic [7:0] tx_mem_q [TX_DEPTH];

  logic [RX_AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [TX_AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_cm_q, tx_cm_d;
  logic [TX_AW:0] tx_uncommitted_d;
  logic           ft_rxfn_q, ft_rxfn_d, ft_txen_q, ft_txen_d;
  logic           proto_err_q, proto_err_d;
  logic           rx_full, rx_push, rx_pop, rx_empty_d;
  logic           tx_push, tx_pop, tx_full_d, tx_commit;

  assign ft_rxfn    = ft_rxfn_q;
  assign ft_txen    = ft_txen_q;
  assign proto_err  = proto_err_q;
  assign ft_data_oe = !ft_oen;

  // RX path: host pushes, FPGA pops.
  assign rx_full       = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                         (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
  assign host_tx_ready = rst_n && !rx_full;
  assign rx_push       = host_tx_valid && host_tx_ready;
  assign rx_pop        = !ft_rdn && !ft_oen && !ft_rxfn_q;
  assign rx_wr_d       = rx_wr_q + {{RX_AW{1'b0}}, rx_push};
  assign rx_rd_d       = rx_rd_q + {{RX_AW{1'b0}}, rx_pop};
  assign rx_empty_d    = (rx_wr_d == rx_rd_d);
  assign ft_data_out   = rx_mem_q[rx_rd_q[RX_AW-1:0]];

  // TX path: FPGA pushes, host pops only what lies below the commit pointer.
  assign tx_push          = !ft_wrn && !ft_txen_q;
  assign host_rx_valid    = rst_n && (tx_cm_q != tx_rd_q);
  assign host_rx_data     = tx_mem_q[tx_rd_q[TX_AW-1:0]];
  assign tx_pop           = host_rx_valid && host_rx_ready;
  assign tx_wr_d          = tx_wr_q + {{TX_AW{1'b0}}, tx_push};
  assign tx_rd_d          = tx_rd_q + {{TX_AW{1'b0}}, tx_pop};
  assign tx_full_d        = (tx_wr_d[TX_AW] != tx_rd_d[TX_AW]) &&
                            (tx_wr_d[TX_AW-1:0] == tx_rd_d[TX_AW-1:0]);
  assign tx_uncommitted_d = tx_wr_d - tx_cm_q;
  assign tx_commit        = !ft_siwun || (tx_uncommitted_d >= PKT_THR);
  assign tx_cm_d          = tx_commit ? tx_wr_d : tx_cm_q;

  // Flags reflect the post-edge occupancy; power save forces both inactive.
  assign ft_rxfn_d = rx_empty_d || !ft_pwrsavn;
  assign ft_txen_d = tx_full_d  || !ft_pwrsavn;

  assign proto_err_d = proto_err_q ||
                       (!ft_rdn && ft_oen)     ||
                       (!ft_wrn && !ft_oen)    ||
                       (!ft_rdn && !ft_wrn)    ||
                       (!ft_rdn && ft_rxfn_q)  ||
                       (!ft_wrn && ft_txen_q);

  always_ff @(posedge ft_clkout) begin
    if (rx_push) rx_mem_q[rx_wr_q[RX_AW-1:0]] <= host_tx_data;
    if (tx_push) tx_mem_q[tx_wr_q[TX_AW-1:0]] <= ft_data_in;
  end

  always_ff @(posedge ft_clkout) begin
    if (!rst_n) begin
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      tx_cm_q     <= '0;
      ft_rxfn_q   <= 1'b1;
      ft_txen_q   <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      tx_cm_q     <= tx_cm_d;
      ft_rxfn_q   <= ft_rxfn_d;
      ft_txen_q   <= ft_txen_d;
      proto_err_q <= proto_err_d;
    end
  end
endmodule

// File: tb/tb_ft245_sync_device.sv
// Randomized bench for ft245_sync_device: queue-based reference model plus decoupled scoreboard monitor.
module tb_ft245_sync_device;
  localparam int DEPTH = 16;
  localparam int PKT   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ft_oen = 1'b1, ft_rdn = 1'b1, ft_wrn = 1'b1, ft_siwun = 1'b1, ft_pwrsavn = 1'b1;
  logic [7:0] ft_data_in = '0, host_tx_data = '0;
  logic       host_tx_valid = 1'b0, host_rx_ready = 1'b0;
  logic       ft_rxfn, ft_txen, ft_data_oe, host_tx_ready, host_rx_valid, proto_err;
  logic [7:0] ft_data_out, host_rx_data;

  ft245_sync_device #(.RX_AW(4), .TX_AW(4), .PKT_SIZE(PKT)) dut (
    .ft_clkout(clk), .rst_n(rst_n), .ft_oen(ft_oen), .ft_rdn(ft_rdn), .ft_wrn(ft_wrn),
    .ft_siwun(ft_siwun), .ft_pwrsavn(ft_pwrsavn), .ft_data_in(ft_data_in),
    .ft_rxfn(ft_rxfn), .ft_txen(ft_txen), .ft_data_out(ft_data_out), .ft_data_oe(ft_data_oe),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int rx_data_checks = 0;
  int tx_data_checks = 0;
  bit chk_en = 1'b0;

  // Reference model: occupancy counts plus expected-byte queues.
  int         rx_cnt = 0, tx_occ = 0, comm_cnt = 0;
  bit         m_rxfn = 1'b1, m_txen = 1'b1, m_err = 1'b0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_pend[$];
  logic [7:0] tx_exp[$];
  bit         rpush, rpop, wpush, hpop;

  always @(posedge clk) begin
    if (!rst_n) begin
      rx_cnt = 0; tx_occ = 0; comm_cnt = 0;
      m_rxfn = 1'b1; m_txen = 1'b1; m_err = 1'b0;
      rx_exp.delete(); tx_pend.delete(); tx_exp.delete();
    end else begin
      rpush = host_tx_valid && (rx_cnt < DEPTH);
      rpop  = !ft_rdn && !ft_oen && !m_rxfn;
      wpush = !ft_wrn && !m_txen;
      hpop  = host_rx_ready && (comm_cnt > 0);
      if ((!ft_rdn && ft_oen) || (!ft_wrn && !ft_oen) || (!ft_rdn && !ft_wrn) ||
          (!ft_rdn && m_rxfn) || (!ft_wrn && m_txen))
        m_err = 1'b1;
      if (rpush) begin rx_exp.push_back(host_tx_data); rx_cnt++; end
      if (rpop) rx_cnt--;
      if (hpop) begin comm_cnt--; tx_occ--; end
      if (wpush) begin tx_pend.push_back(ft_data_in); tx_occ++; end
      if (!ft_siwun || tx_pend.size() >= PKT) begin
        while (tx_pend.size() > 0) begin
          tx_exp.push_back(tx_pend.pop_front());
          comm_cnt++;
        end
      end
      m_rxfn = (rx_cnt == 0) || !ft_pwrsavn;
      m_txen = (tx_occ == DEPTH) || !ft_pwrsavn;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: mid-cycle, compares flags and pops expected bytes on each transfer the DUT presents.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ft_rxfn", {7'b0, ft_rxfn}, {7'b0, m_rxfn});
      chk("ft_txen", {7'b0, ft_txen}, {7'b0, m_txen});
      chk("proto_err", {7'b0, proto_err}, {7'b0, m_err});
      chk("ft_data_oe", {7'b0, ft_data_oe}, {7'b0, !ft_oen});
      chk("host_tx_ready", {7'b0, host_tx_ready}, {7'b0, rst_n && (rx_cnt < DEPTH)});
      chk("host_rx_valid", {7'b0, host_rx_valid}, {7'b0, rst_n && (comm_cnt > 0)});
      if (!ft_rdn && !ft_oen && !ft_rxfn) begin
        if (rx_exp.size() == 0) chk("rx_pop_when_empty", 8'd1, 8'd0);
        else begin chk("ft_data_out", ft_data_out, rx_exp.pop_front()); rx_data_checks++; end
      end
      if (host_rx_valid && host_rx_ready) begin
        if (tx_exp.size() == 0) chk("host_rx_pop_uncommitted", 8'd1, 8'd0);
        else begin chk("host_rx_data", host_rx_data, tx_exp.pop_front()); tx_data_checks++; end
      end
    end
  end

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic run_phase(input int n, input int pv, input int pr, input int prd, input int pw,
                           input int psiw, input int perr, input int ppwr, input int prst);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n         = !pct(prst);
      host_tx_valid = pct(pv);
      host_tx_data  = 8'($urandom);
      host_rx_ready = pct(pr);
      ft_data_in    = 8'($urandom);
      ft_siwun      = !pct(psiw);
      ft_pwrsavn    = !pct(ppwr);
      if (pct(prd)) begin
        ft_oen = 1'b0; ft_wrn = 1'b1;
        ft_rdn = !(!m_rxfn && pct(70));
      end else begin
        ft_oen = 1'b1; ft_rdn = 1'b1;
        ft_wrn = !(!m_txen && pct(pw));
      end
      if (pct(perr)) {ft_oen, ft_rdn, ft_wrn} = 3'($urandom);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    // Fill both FIFOs with no consumer, then strobe a write against a full TX FIFO.
    run_phase(40, 100, 0, 0, 100, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    host_tx_valid = 1'b0; ft_oen = 1'b1; ft_rdn = 1'b1; ft_wrn = 1'b0;
    // Drain both sides, then random traffic without and with protocol noise and resets.
    run_phase(40, 0, 100, 100, 0, 0, 0, 0, 0);
    run_phase(20, 0, 0, 0, 0, 0, 0, 0, 100);
    run_phase(3000, 50, 50, 50, 60, 10, 0, 5, 0);
    run_phase(2000, 60, 40, 50, 60, 10, 2, 5, 1);
    run_phase(20, 0, 100, 100, 0, 100, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (rx_data_checks < 50 || tx_data_checks < 50) begin
      miscompares++;
      $display("FAIL data_traffic: rx checks %0d, tx checks %0d, required at least 50 each",
               rx_data_checks, tx_data_checks);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
